// File: rtl/izh_pkg.sv
// izh_pkg -- shared definitions for the Izhikevich neuron engine.
//   * FSM state type and state constants for izh_neuron_array.
//   * Model constants K1 (0.04), K2 (5), K3 (140), V_PEAK (30), V_REST (-65)
//     and U_REST (-13), each returned already scaled by 2^frac.
//   * Golden helpers izh_v_next / izh_u_next: a plain-integer description of
//     one Euler step (pre-spike, reduced to width bits) for reference use.
// Optional build macro: IZH_SATURATE_EN (selects clamping instead of wrap in
// the datapath; the golden helpers take the choice as an argument).
package izh_pkg;

  typedef logic [1:0] izh_state_t;
  localparam izh_state_t ST_IDLE = 2'd0;
  localparam izh_state_t ST_RUN  = 2'd1;
  localparam izh_state_t ST_DONE = 2'd2;

  // 0.04 has no exact binary form; floor(0.04 * 2^frac).
  function automatic longint izh_k1(input int frac);
    return (longint'(4) << frac) / 100;
  endfunction
  function automatic longint izh_k2(input int frac);
    return longint'(5) << frac;
  endfunction
  function automatic longint izh_k3(input int frac);
    return longint'(140) << frac;
  endfunction
  function automatic longint izh_v_peak(input int frac);
    return longint'(30) << frac;
  endfunction
  function automatic longint izh_v_rest(input int frac);
    return -(longint'(65) << frac);
  endfunction
  function automatic longint izh_u_rest(input int frac);
    return -(longint'(13) << frac);
  endfunction

  // Two's-complement wrap of x to a signed field of 'bits' bits.
  function automatic longint izh_wrap(input longint x, input int bits);
    longint r;
    if (bits >= 64) return x;
    r = x <<< (64 - bits);
    return r >>> (64 - bits);
  endfunction

  // Reduction to the state width: clamp or wrap.
  function automatic longint izh_reduce(input longint x, input int width, input bit sat);
    longint hi;
    longint lo;
    hi = (longint'(1) << (width - 1)) - 1;
    lo = -(longint'(1) << (width - 1));
    if (sat) begin
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
    end
    return izh_wrap(x, width);
  endfunction

  // v' before spike handling; intermediates live in a 2*width+8 bit field.
  function automatic longint izh_v_next(input longint v, input longint u, input longint i_cur,
                                        input longint dt, input int width, input int frac,
                                        input bit sat);
    int     w2;
    longint sq;
    longint lin;
    longint dv;
    longint st;
    w2  = 2 * width + 8;
    sq  = izh_wrap(izh_k1(frac) * v * v, w2) >>> (2 * frac);
    lin = izh_wrap(izh_k2(frac) * v, w2) >>> frac;
    dv  = izh_wrap(sq + lin + izh_k3(frac) - u + i_cur, w2);
    st  = izh_wrap(dt * dv, w2) >>> frac;
    return izh_reduce(izh_wrap(v + st, w2), width, sat);
  endfunction

  // u' before spike handling.
  function automatic longint izh_u_next(input longint v, input longint u, input longint a,
                                        input longint b, input longint dt, input int width,
                                        input int frac, input bit sat);
    int     w2;
    longint bv;
    longint du;
    longint st;
    w2 = 2 * width + 8;
    bv = izh_wrap(b * v, w2) >>> frac;
    du = izh_wrap(a * izh_wrap(bv - u, w2), w2) >>> frac;
    st = izh_wrap(dt * du, w2) >>> frac;
    return izh_reduce(izh_wrap(u + st, w2), width, sat);
  endfunction

endpackage

// File: rtl/izh_update_core.sv
// izh_update_core -- combinational single-neuron Izhikevich update.
// Ports: v, u (current state), i_cur (input current), a, b, c, d, dt (model
// parameters), v_new / u_new (state to write back), spike (v' reached peak).
// Macro IZH_SATURATE_EN: every reduction to WIDTH clamps instead of wrapping.
module izh_update_core
  import izh_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic signed [WIDTH-1:0] v,
  input  logic signed [WIDTH-1:0] u,
  input  logic signed [WIDTH-1:0] i_cur,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] c,
  input  logic signed [WIDTH-1:0] d,
  input  logic signed [WIDTH-1:0] dt,
  output logic signed [WIDTH-1:0] v_new,
  output logic signed [WIDTH-1:0] u_new,
  output logic                    spike
);
  // Wide enough that v*v*K1 of any WIDTH-bit v cannot overflow.
  localparam int W2 = 2 * WIDTH + 8;
  localparam logic signed [W2-1:0]    K1_W     = W2'(izh_k1(FRAC));
  localparam logic signed [W2-1:0]    K2_W     = W2'(izh_k2(FRAC));
  localparam logic signed [W2-1:0]    K3_W     = W2'(izh_k3(FRAC));
  localparam logic signed [WIDTH-1:0] V_PEAK_W = WIDTH'(izh_v_peak(FRAC));

`ifdef IZH_SATURATE_EN
  localparam logic signed [W2-1:0] SAT_MAX = {{(W2-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [W2-1:0] SAT_MIN = {{(W2-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

  function automatic logic signed [W2-1:0] sext(input logic signed [WIDTH-1:0] x);
    return {{(W2-WIDTH){x[WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [WIDTH-1:0] reduce(input logic signed [W2-1:0] x);
`ifdef IZH_SATURATE_EN
    if (x > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
    else if (x < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else                  return x[WIDTH-1:0];
`else
    return x[WIDTH-1:0];
`endif
  endfunction

  logic signed [W2-1:0] vx, ux, ix, ax, bx, dx, dtx;
  logic signed [W2-1:0] sq_t, lin_t, dv, v_step, v_raw;
  logic signed [W2-1:0] bv_t, du, u_step, u_raw, ud_raw;
  logic signed [WIDTH-1:0] v_red, u_red, ud_red;

  assign vx  = sext(v);
  assign ux  = sext(u);
  assign ix  = sext(i_cur);
  assign ax  = sext(a);
  assign bx  = sext(b);
  assign dx  = sext(d);
  assign dtx = sext(dt);

  // dv = K1*v^2 + K2*v + K3 - u + I, each product rescaled back to FRAC.
  assign sq_t   = (K1_W * vx * vx) >>> (2 * FRAC);
  assign lin_t  = (K2_W * vx) >>> FRAC;
  assign dv     = sq_t + lin_t + K3_W - ux + ix;
  assign v_step = (dtx * dv) >>> FRAC;
  assign v_raw  = vx + v_step;

  // du = a*(b*v - u); uses the old v, never v'.
  assign bv_t   = (bx * vx) >>> FRAC;
  assign du     = (ax * (bv_t - ux)) >>> FRAC;
  assign u_step = (dtx * du) >>> FRAC;
  assign u_raw  = ux + u_step;

  assign v_red  = reduce(v_raw);
  assign u_red  = reduce(u_raw);
  // Post-spike u is computed from the already-reduced u'.
  assign ud_raw = sext(u_red) + dx;
  assign ud_red = reduce(ud_raw);

  assign spike = (v_red >= V_PEAK_W);
  assign v_new = spike ? c : v_red;
  assign u_new = spike ? ud_red : u_red;

endmodule

// File: rtl/izh_neuron_array.sv
// izh_neuron_array -- time-multiplexed Izhikevich engine for N_NEURONS cells.
// Ports: clk/rst (sync active-high), step_valid/step_ready (step handshake,
// ready only in IDLE), i_in (packed per-neuron currents), a/b/c/d/dt (shared
// parameters), step_done (one-cycle pulse in DONE), spike_vec (spikes of the
// last completed step), rd_idx/rd_v/rd_u (combinational state readback).
// Macro IZH_SATURATE_EN: clamp instead of wrap in izh_update_core.
module izh_neuron_array
  import izh_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int WIDTH     = 16,
  parameter int FRAC      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         step_valid,
  output logic                         step_ready,
  input  logic [N_NEURONS*WIDTH-1:0]   i_in,
  input  logic signed [WIDTH-1:0]      a,
  input  logic signed [WIDTH-1:0]      b,
  input  logic signed [WIDTH-1:0]      c,
  input  logic signed [WIDTH-1:0]      d,
  input  logic signed [WIDTH-1:0]      dt,
  output logic                         step_done,
  output logic [N_NEURONS-1:0]         spike_vec,
  input  logic [$clog2(N_NEURONS)-1:0] rd_idx,
  output logic signed [WIDTH-1:0]      rd_v,
  output logic signed [WIDTH-1:0]      rd_u
);
  localparam int IW = $clog2(N_NEURONS);
  localparam logic signed [WIDTH-1:0] V_REST_W = WIDTH'(izh_v_rest(FRAC));
  localparam logic signed [WIDTH-1:0] U_REST_W = WIDTH'(izh_u_rest(FRAC));

  izh_state_t                   state_reg;
  logic [IW-1:0]                idx_reg;
  logic [N_NEURONS*WIDTH-1:0]   i_cap_reg;
  logic signed [WIDTH-1:0]      a_reg, b_reg, c_reg, d_reg, dt_reg;
  logic [N_NEURONS-1:0]         spike_next_reg, spike_vec_reg, spike_acc;
  logic signed [WIDTH-1:0]      v_mem_reg [N_NEURONS];
  logic signed [WIDTH-1:0]      u_mem_reg [N_NEURONS];
  logic signed [WIDTH-1:0]      i_arr     [N_NEURONS];
  logic signed [WIDTH-1:0]      core_v, core_u;
  logic                         core_spike;

  // Unpack the captured currents so the core can be muxed by index.
  for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_iunpack
    assign i_arr[gi] = i_cap_reg[gi*WIDTH +: WIDTH];
  end

  izh_update_core #(.WIDTH(WIDTH), .FRAC(FRAC)) u_core (
    .v     (v_mem_reg[idx_reg]),
    .u     (u_mem_reg[idx_reg]),
    .i_cur (i_arr[idx_reg]),
    .a     (a_reg),
    .b     (b_reg),
    .c     (c_reg),
    .d     (d_reg),
    .dt    (dt_reg),
    .v_new (core_v),
    .u_new (core_u),
    .spike (core_spike)
  );

  // Spike flags accumulated so far, including the neuron being updated now,
  // so the final vector can be committed on the last RUN edge and is already
  // visible during DONE.
  always_comb begin
    spike_acc          = spike_next_reg;
    spike_acc[idx_reg] = core_spike;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      i_cap_reg      <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      c_reg          <= '0;
      d_reg          <= '0;
      dt_reg         <= '0;
      spike_next_reg <= '0;
      spike_vec_reg  <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_mem_reg[k] <= V_REST_W;
        u_mem_reg[k] <= U_REST_W;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (step_valid) begin
            i_cap_reg      <= i_in;
            a_reg          <= a;
            b_reg          <= b;
            c_reg          <= c;
            d_reg          <= d;
            dt_reg         <= dt;
            idx_reg        <= '0;
            spike_next_reg <= '0;
            state_reg      <= ST_RUN;
          end
        end
        ST_RUN: begin
          v_mem_reg[idx_reg] <= core_v;
          u_mem_reg[idx_reg] <= core_u;
          spike_next_reg     <= spike_acc;
          if (idx_reg == IW'(N_NEURONS - 1)) begin
            spike_vec_reg <= spike_acc;
            state_reg     <= ST_DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign step_ready = (state_reg == ST_IDLE);
  assign step_done  = (state_reg == ST_DONE);
  assign spike_vec  = spike_vec_reg;
  assign rd_v       = v_mem_reg[rd_idx];
  assign rd_u       = u_mem_reg[rd_idx];

endmodule

// File: tb/tb_izh_neuron_array.sv
// tb_izh_neuron_array -- randomized, model-checked bench for izh_neuron_array.
// A step-level model computes a whole sweep at accept time from the golden
// helpers and the spike/reset rule, and publishes it in the DONE cycle; a
// negedge process compares handshake, spike_vec and readback every cycle.
// Honors IZH_SATURATE_EN for the overflow expectations.
module tb_izh_neuron_array;
  import izh_pkg::*;

  localparam int N = 8;
  localparam int W = 16;
  localparam int F = 8;
`ifdef IZH_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam longint VREST = -16640;
  localparam longint UREST = -3328;
  localparam longint VPEAK = 7680;

  logic                clk = 1'b0;
  logic                rst;
  logic                step_valid;
  logic                step_ready;
  logic [N*W-1:0]      i_in;
  logic signed [W-1:0] a, b, c, d, dt;
  logic                step_done;
  logic [N-1:0]        spike_vec;
  logic [2:0]          rd_idx;
  logic signed [W-1:0] rd_v, rd_u;

  always #5 clk = ~clk;

  izh_neuron_array #(.N_NEURONS(N), .WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(step_ready),
    .i_in(i_in), .a(a), .b(b), .c(c), .d(d), .dt(dt),
    .step_done(step_done), .spike_vec(spike_vec),
    .rd_idx(rd_idx), .rd_v(rd_v), .rd_u(rd_u)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint     mv [N];
  longint     mu [N];
  longint     pv [N];
  longint     pu [N];
  logic [N-1:0] mspk = '0;
  logic [N-1:0] pspk;
  int         phase = 0;       // 0 = idle, 1..N = sweeping, N+1 = done
  bit         model_valid = 1'b0;
  int         steps_done = 0;

  task automatic model_step();
    longint ik, vn, un;
    pspk = '0;
    for (int k = 0; k < N; k++) begin
      ik = longint'($signed(i_in[k*W +: W]));
      vn = izh_v_next(mv[k], mu[k], ik, longint'(dt), W, F, SAT);
      un = izh_u_next(mv[k], mu[k], longint'(a), longint'(b), longint'(dt), W, F, SAT);
      if (vn >= VPEAK) begin
        pv[k]   = longint'(c);
        pu[k]   = izh_reduce(un + longint'(d), W, SAT);
        pspk[k] = 1'b1;
      end else begin
        pv[k] = vn;
        pu[k] = un;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) begin
      model_valid = 1'b1;
      phase = 0;
      mspk = '0;
      for (int k = 0; k < N; k++) begin
        mv[k] = VREST;
        mu[k] = UREST;
      end
    end else if (phase == 0) begin
      if (step_valid) begin
        model_step();
        phase = 1;
      end
    end else if (phase == N + 1) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == N + 1) begin
        for (int k = 0; k < N; k++) begin
          mv[k] = pv[k];
          mu[k] = pu[k];
        end
        mspk = pspk;
        steps_done++;
        $display("step %0d committed: spike_vec=%h v0=%0d u0=%0d", steps_done, pspk, pv[0], pu[0]);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      chk("step_ready", step_ready, phase == 0);
      chk("step_done", step_done, phase == N + 1);
      chk("spike_vec", spike_vec, mspk);
      if (phase == 0 || phase == N + 1) begin
        chk("rd_v", rd_v, mv[rd_idx]);
        chk("rd_u", rd_u, mu[rd_idx]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_defaults();
    a = 16'sd5; b = 16'sd51; c = -16'sd16640; d = 16'sd2048; dt = 16'sd256;
  endtask

  task automatic do_step(output int lat);
    @(posedge clk); #1;
    step_valid = 1'b1;
    @(posedge clk); #1;
    step_valid = 1'b0;
    lat = 1;
    while (step_done !== 1'b1 && lat < 40) begin
      rd_idx = 3'($urandom_range(0, N - 1));
      @(posedge clk); #1;
      lat++;
    end
    chk("done_latency", lat, N + 1);
    @(posedge clk); #1;
    chk("ready_after_done", step_ready, 1);
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < N; k++) begin
      rd_idx = 3'(k);
      #1;
      chk({tag, "_v"}, rd_v, VREST);
      chk({tag, "_u"}, rd_u, UREST);
    end
    chk({tag, "_spike"}, spike_vec, 0);
    chk({tag, "_ready"}, step_ready, 1);
    chk({tag, "_done"}, step_done, 0);
  endtask

  initial begin
    int     lat, found, cnt, cyc, last, nodone;
    longint pv3, pu3;
    rst = 1'b1; step_valid = 1'b0; i_in = '0; rd_idx = '0;
    set_defaults();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values.
    check_reset_state("reset");

    // Golden helpers pinned to hand-computed values.
    chk("golden_v_rest", izh_v_next(VREST, UREST, 0, 256, W, F, SAT), -18422);
    chk("golden_u_rest", izh_u_next(VREST, UREST, 5, 51, 256, W, F, SAT), -3328);

    // One step with zero current.
    do_step(lat);
    rd_idx = 3'd0; #1;
    chk("step1_v0", rd_v, -18422);
    chk("step1_u0", rd_u, -3328);
    chk("step1_spike", spike_vec, 0);

    // Drive neuron 3 until its first spike.
    i_in[3*W +: W] = 16'sd5120;
    found = 0;
    for (int s = 0; s < 60 && found == 0; s++) begin
      pv3 = mv[3];
      pu3 = mu[3];
      do_step(lat);
      if (spike_vec != '0) begin
        found = 1;
        chk("spike3_vec", spike_vec, 8'h08);
        rd_idx = 3'd3; #1;
        chk("spike3_v", rd_v, -16640);
        chk("spike3_u", rd_u, izh_u_next(pv3, pu3, 5, 51, 256, W, F, SAT) + 2048);
      end
    end
    chk("spike3_found", found, 1);

    // Randomized currents, some steps with randomized parameters.
    for (int s = 0; s < 12; s++) begin
      for (int k = 0; k < N; k++) i_in[k*W +: W] = W'($urandom_range(0, 8000) - 2000);
      if (s % 4 == 3) begin
        a  = W'($urandom_range(1, 40));
        b  = W'($urandom_range(20, 80));
        d  = W'($urandom_range(0, 4000));
        dt = W'($urandom_range(64, 512));
      end else begin
        set_defaults();
      end
      do_step(lat);
    end
    set_defaults();

    // step_valid held high: five back-to-back steps, inputs churning every cycle.
    @(posedge clk); #1;
    step_valid = 1'b1;
    cnt = 0; cyc = 0; last = -1;
    while (cnt < 5 && cyc < 80) begin
      for (int k = 0; k < N; k++) i_in[k*W +: W] = W'($urandom_range(0, 8000) - 2000);
      a  = W'($urandom_range(1, 40));
      b  = W'($urandom_range(20, 80));
      c  = W'($urandom_range(0, 6000) - 17000);
      d  = W'($urandom_range(0, 4000));
      dt = W'($urandom_range(64, 512));
      @(posedge clk); #1;
      cyc++;
      if (step_done === 1'b1) begin
        cnt++;
        if (last >= 0) chk("done_spacing", cyc - last, N + 2);
        last = cyc;
        if (cnt == 5) step_valid = 1'b0;
      end
    end
    step_valid = 1'b0;
    chk("held_done_count", cnt, 5);
    repeat (12) @(posedge clk);
    #1 set_defaults();

    // Reset during RUN cycle 3 aborts the sweep.
    i_in = '0;
    @(posedge clk); #1;
    step_valid = 1'b1;
    @(posedge clk); #1;
    step_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("abort");
    nodone = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (step_done !== 1'b0) nodone++;
    end
    chk("abort_no_done", nodone, 0);

    // Overflow of v' on neuron 0 from rest.
    i_in = '0;
    i_in[0 +: W] = 16'sd32767;
    dt = 16'sd512;
    do_step(lat);
    rd_idx = 3'd0; #1;
`ifdef IZH_SATURATE_EN
    chk("sat_spike0", spike_vec[0], 1);
    chk("sat_v0", rd_v, -16640);
    chk("sat_u0", rd_u, -1280);
`else
    chk("wrap_spike0", spike_vec[0], 0);
    chk("wrap_v0", rd_v, -20206);
    chk("wrap_u0", rd_u, -3328);
`endif
    set_defaults();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
